// File: rtl/cp0_regfile.sv
// ---------------------------------------------------------------------------
// cp0_regfile
// Parametrised MIPS CP0 register file. It sits beside the MEM/WB stage and
// takes MTC0 writes plus exception/ERET commits from the commit stage. MFC0
// reads are combinational and show the values held before the clock edge.
//
// Ports
//   clk            clock; every register updates on its rising edge
//   rst            asynchronous, active-low reset
//   we_i           MTC0 write enable
//   waddr_i        MTC0 register number
//   raddr_i        MFC0 register number
//   data_i         MTC0 write data
//   data_o         MFC0 read data (combinational)
//   int_i          level-sensitive hardware interrupt lines
//   exc_valid_i    an exception commits this cycle
//   exc_code_i     ExcCode of the committing exception
//   exc_pc_i       PC of the faulting instruction
//   exc_bd_i       the faulting instruction is in a branch delay slot
//   exc_badvaddr_i faulting address, captured for AdEL/AdES
//   eret_i         an ERET commits this cycle
//   count_o, compare_o, status_o, cause_o, epc_o   register contents
//   int_o          interrupt request to the pipeline
//   timer_int_o    timer interrupt pending (Cause.TI)
// ---------------------------------------------------------------------------
module cp0_regfile #(
  parameter int          HW_INT_NUM   = 6,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  input  logic [HW_INT_NUM-1:0] int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  int_o,
  output logic                  timer_int_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  // Prescaler width; a divide-by-one still keeps a one-bit phase register
  // that simply sits at zero and wraps every cycle.
  localparam int          PW       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(COUNT_DIV - 1);

  logic [31:0]           count_q;
  logic [31:0]           compare_q;
  logic [31:0]           epc_q;
  logic [31:0]           badvaddr_q;
  logic [PW-1:0]         presc_q;
  logic [7:0]            im_q;
  logic                  exl_q;
  logic                  ie_q;
  logic                  bd_q;
  logic                  ti_q;
  logic [1:0]            ip_sw_q;
  logic [4:0]            exc_code_q;
  logic [HW_INT_NUM-1:0] hw_q;

  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        presc_wrap;
  logic        count_inc;
  logic [31:0] count_plus;
  logic        timer_hit;
  logic [5:0]  hw_ip;
  logic [5:0]  ip_hi;
  logic [31:0] status_val;
  logic [31:0] cause_val;

  // MTC0 decode. An exception owns Status, Cause and EPC in its cycle and an
  // ERET owns Status, so a same-cycle MTC0 to those registers is dropped.
  // Count and Compare are never touched by commits and always accept writes.
  assign wr_count   = we_i && (waddr_i == REG_COUNT);
  assign wr_compare = we_i && (waddr_i == REG_COMPARE);
  assign wr_status  = we_i && (waddr_i == REG_STATUS) && !exc_valid_i && !eret_i;
  assign wr_cause   = we_i && (waddr_i == REG_CAUSE) && !exc_valid_i;
  assign wr_epc     = we_i && (waddr_i == REG_EPC) && !exc_valid_i;

  // A Count write overrides the increment that would otherwise happen on a
  // prescaler wrap, so the match detector must only see real increments.
  assign presc_wrap = (presc_q == DIV_LAST);
  assign count_inc  = presc_wrap && !wr_count;
  assign count_plus = count_q + 32'd1;
  assign timer_hit  = count_inc && (count_plus == compare_q) && (compare_q != 32'd0);

  // Pad the sampled lines out to the full six IP bits; the timer flag shares
  // the top line.
  always_comb begin
    hw_ip                 = '0;
    hw_ip[HW_INT_NUM-1:0] = hw_q;
  end

  assign ip_hi = hw_ip | {ti_q, 5'b0};

  assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_val  = {bd_q, ti_q, 14'b0, ip_hi, ip_sw_q, 1'b0, exc_code_q, 2'b0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      presc_q <= '0;
    end else if (wr_count) begin
      count_q <= data_i;
      presc_q <= '0;
    end else begin
      if (count_inc) begin
        count_q <= count_plus;
      end
      presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
    end
  end

  // TI is sticky; only a Compare write clears it, and that write wins over a
  // match landing on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else if (wr_compare) begin
      compare_q <= data_i;
      ti_q      <= 1'b0;
    end else if (timer_hit) begin
      ti_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
    end else if (exc_valid_i) begin
      exl_q <= 1'b1;
    end else if (eret_i) begin
      exl_q <= 1'b0;
    end else if (wr_status) begin
      im_q  <= data_i[15:8];
      exl_q <= data_i[1];
      ie_q  <= data_i[0];
    end
  end

  // EPC and BD are only captured on the outermost exception; a nested one
  // (EXL already set) keeps the original return point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_sw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else if (exc_valid_i) begin
      exc_code_q <= exc_code_i;
      if (!exl_q) begin
        bd_q  <= exc_bd_i;
        epc_q <= exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
      end
      if ((exc_code_i == 5'd4) || (exc_code_i == 5'd5)) begin
        badvaddr_q <= exc_badvaddr_i;
      end
    end else begin
      if (wr_cause) begin
        ip_sw_q <= data_i[9:8];
      end
      if (wr_epc) begin
        epc_q <= data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hw_q <= '0;
    end else begin
      hw_q <= int_i;
    end
  end

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      REG_BADVADDR: data_o = badvaddr_q;
      REG_COUNT:    data_o = count_q;
      REG_COMPARE:  data_o = compare_q;
      REG_STATUS:   data_o = status_val;
      REG_CAUSE:    data_o = cause_val;
      REG_EPC:      data_o = epc_q;
      REG_PRID:     data_o = PRID_VALUE;
      REG_CONFIG:   data_o = CONFIG_VALUE;
      default:      data_o = 32'd0;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_val;
  assign cause_o     = cause_val;
  assign epc_o       = epc_q;
  assign timer_int_o = ti_q;
  assign int_o       = ie_q && !exl_q && (|(cause_val[15:8] & im_q));

endmodule

// File: tb/tb_cp0_regfile.sv
// ---------------------------------------------------------------------------
// tb_cp0_regfile
// Directed testbench for cp0_regfile with HW_INT_NUM=6 and COUNT_DIV=2.
// Inputs change one time unit after a rising edge and outputs are sampled in
// the same window, away from the active edge.
// ---------------------------------------------------------------------------
module tb_cp0_regfile;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [5:0]  int_i;
  logic        exc_valid_i;
  logic [4:0]  exc_code_i;
  logic [31:0] exc_pc_i;
  logic        exc_bd_i;
  logic [31:0] exc_badvaddr_i;
  logic        eret_i;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        int_o;
  logic        timer_int_o;

  int checkCount = 0;
  int errorCount = 0;
  logic [31:0] rdData;

  cp0_regfile #(
    .HW_INT_NUM  (6),
    .COUNT_DIV   (2),
    .PRID_VALUE  (32'h0000_4220),
    .CONFIG_VALUE(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .we_i          (we_i),
    .waddr_i       (waddr_i),
    .raddr_i       (raddr_i),
    .data_i        (data_i),
    .data_o        (data_o),
    .int_i         (int_i),
    .exc_valid_i   (exc_valid_i),
    .exc_code_i    (exc_code_i),
    .exc_pc_i      (exc_pc_i),
    .exc_bd_i      (exc_bd_i),
    .exc_badvaddr_i(exc_badvaddr_i),
    .eret_i        (eret_i),
    .count_o       (count_o),
    .compare_o     (compare_o),
    .status_o      (status_o),
    .cause_o       (cause_o),
    .epc_o         (epc_o),
    .int_o         (int_o),
    .timer_int_o   (timer_int_o)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to one time unit past the next rising edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // One-cycle MTC0 write.
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    we_i    = 1'b1;
    waddr_i = addr;
    data_i  = data;
    stepClock();
    we_i    = 1'b0;
  endtask

  task automatic raiseException(input logic [4:0] code, input logic [31:0] pc,
                                input logic bd, input logic [31:0] badAddr);
    exc_valid_i    = 1'b1;
    exc_code_i     = code;
    exc_pc_i       = pc;
    exc_bd_i       = bd;
    exc_badvaddr_i = badAddr;
    stepClock();
    exc_valid_i    = 1'b0;
  endtask

  task automatic doEret();
    eret_i = 1'b1;
    stepClock();
    eret_i = 1'b0;
  endtask

  // MFC0 read; costs one time unit, never crosses an edge when used sparingly.
  task automatic readReg(input logic [4:0] addr, output logic [31:0] data);
    raddr_i = addr;
    #1;
    data = data_o;
  endtask

  initial begin
    rst            = 1'b0;
    we_i           = 1'b0;
    waddr_i        = '0;
    raddr_i        = '0;
    data_i         = '0;
    int_i          = '0;
    exc_valid_i    = 1'b0;
    exc_code_i     = '0;
    exc_pc_i       = '0;
    exc_bd_i       = 1'b0;
    exc_badvaddr_i = '0;
    eret_i         = 1'b0;

    #23;
    rst = 1'b1;
    checkOutput("rst_status", status_o, 32'h0040_0000);
    checkOutput("rst_count", count_o, 32'd0);

    // Dirty the state, then pulse reset mid-cycle.
    stepClock();
    raiseException(5'd4, 32'h0000_0100, 1'b0, 32'h0000_DEAD);
    checkOutput("pre_epc", epc_o, 32'h0000_0100);
    applyStimulus(5'd9, 32'd123);
    checkOutput("pre_count", count_o, 32'd123);
    rst = 1'b0;
    #1;
    checkOutput("async_count", count_o, 32'd0);
    checkOutput("async_status", status_o, 32'h0040_0000);
    checkOutput("async_cause", cause_o, 32'd0);
    checkOutput("async_epc", epc_o, 32'd0);
    checkOutput("async_int", {31'd0, int_o}, 32'd0);
    readReg(5'd8, rdData);
    checkOutput("async_badvaddr", rdData, 32'd0);
    readReg(5'd15, rdData);
    checkOutput("prid", rdData, 32'h0000_4220);
    rst = 1'b1;

    // Timer: Count 0 -> 5 takes ten clocks with divide-by-two.
    applyStimulus(5'd11, 32'd5);
    applyStimulus(5'd9, 32'd0);
    for (int i = 0; i < 9; i++) stepClock();
    checkOutput("count_9clk", count_o, 32'd4);
    checkOutput("ti_before", {31'd0, timer_int_o}, 32'd0);
    stepClock();
    checkOutput("count_10clk", count_o, 32'd5);
    checkOutput("ti_set", {31'd0, timer_int_o}, 32'd1);
    checkOutput("cause_ti_ip7", cause_o & 32'h4000_8000, 32'h4000_8000);
    stepClock();
    stepClock();
    checkOutput("ti_sticky", {31'd0, timer_int_o}, 32'd1);
    applyStimulus(5'd11, 32'd9);
    checkOutput("ti_clear", {31'd0, timer_int_o}, 32'd0);
    applyStimulus(5'd11, 32'd0);
    checkOutput("compare_zero", compare_o, 32'd0);

    // Hardware interrupt path and EXL masking.
    applyStimulus(5'd12, 32'h0000_0401);
    checkOutput("status_401", status_o, 32'h0040_0401);
    int_i = 6'b000001;
    checkOutput("int_latency", {31'd0, int_o}, 32'd0);
    stepClock();
    checkOutput("cause_ip2", {31'd0, cause_o[10]}, 32'd1);
    checkOutput("int_on", {31'd0, int_o}, 32'd1);
    raiseException(5'd0, 32'h0000_0200, 1'b0, 32'd0);
    checkOutput("exc_exl", status_o, 32'h0040_0403);
    checkOutput("exc_int_off", {31'd0, int_o}, 32'd0);
    doEret();
    checkOutput("eret_int_on", {31'd0, int_o}, 32'd1);
    checkOutput("eret_status", status_o, 32'h0040_0401);
    int_i = 6'b000000;

    // Delay-slot exception followed by a nested one.
    raiseException(5'd4, 32'hBFC0_0100, 1'b1, 32'h0000_0003);
    checkOutput("bd_epc", epc_o, 32'hBFC0_00FC);
    checkOutput("bd_cause", cause_o, 32'h8000_0010);
    readReg(5'd8, rdData);
    checkOutput("bd_badvaddr", rdData, 32'h0000_0003);
    raiseException(5'd8, 32'h8000_0000, 1'b0, 32'h0000_0055);
    checkOutput("nest_epc", epc_o, 32'hBFC0_00FC);
    checkOutput("nest_cause", cause_o, 32'h8000_0020);
    readReg(5'd8, rdData);
    checkOutput("nest_badvaddr", rdData, 32'h0000_0003);

    // Write masks.
    applyStimulus(5'd12, 32'hFFFF_FFFF);
    checkOutput("mask_status", status_o, 32'h0040_FF03);
    applyStimulus(5'd13, 32'hFFFF_FFFF);
    checkOutput("mask_cause", cause_o, 32'h8000_0320);
    applyStimulus(5'd8, 32'hFFFF_FFFF);
    readReg(5'd8, rdData);
    checkOutput("mask_badvaddr", rdData, 32'h0000_0003);
    readReg(5'd5, rdData);
    checkOutput("unmapped_read", rdData, 32'd0);
    checkOutput("mask_exl_noint", {31'd0, int_o}, 32'd0);
    doEret();
    checkOutput("sw_int", {31'd0, int_o}, 32'd1);

    // Exception beats a same-cycle MTC0 to EPC.
    we_i        = 1'b1;
    waddr_i     = 5'd14;
    data_i      = 32'h0000_1234;
    exc_valid_i = 1'b1;
    exc_code_i  = 5'd0;
    exc_pc_i    = 32'h0000_0400;
    exc_bd_i    = 1'b0;
    stepClock();
    we_i        = 1'b0;
    exc_valid_i = 1'b0;
    checkOutput("sim_exc_epc", epc_o, 32'h0000_0400);

    // ERET beats a same-cycle MTC0 to Status.
    we_i    = 1'b1;
    waddr_i = 5'd12;
    data_i  = 32'h0000_0403;
    eret_i  = 1'b1;
    stepClock();
    we_i    = 1'b0;
    eret_i  = 1'b0;
    checkOutput("sim_eret_status", status_o, 32'h0040_FF01);

    // Count write on the wrap cycle wins and restarts the prescaler.
    applyStimulus(5'd9, 32'd100);
    stepClock();
    checkOutput("wrap_pre", count_o, 32'd100);
    applyStimulus(5'd9, 32'd7);
    checkOutput("wrap_write", count_o, 32'd7);
    stepClock();
    checkOutput("wrap_phase", count_o, 32'd7);
    stepClock();
    checkOutput("wrap_inc", count_o, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
